// File: rtl/raptor64_bitfield_unpacker_pkg.sv
// Shared widths, types and the 0=64 width decode used by the bitfield
// unpacker and the reusable field-extract datapath.
package raptor64_bitfield_unpacker_pkg;

  localparam int BF_DW   = 64;
  localparam int BF_BUFW = 2 * BF_DW;
  localparam int BF_CNTW = 8;
  localparam int BF_WW   = 7;

  typedef logic [BF_WW-1:0]   bf_width_t;
  typedef logic [BF_CNTW-1:0] bf_cnt_t;

  // Request width field is 6 bits; the all-zero code stands for a full word.
  function automatic bf_width_t bf_width_decode(input logic [5:0] enc);
    bf_width_t w;
    if (enc == 6'd0) w = bf_width_t'(BF_DW);
    else             w = {1'b0, enc};
    return w;
  endfunction

endpackage

// File: rtl/raptor64_bitfield_unpacker_if.sv
// Word-in / request-in / field-out handshake bundle of the bitfield unpacker.
interface raptor64_bitfield_unpacker_if;
  import raptor64_bitfield_unpacker_pkg::*;

  logic               in_valid_i;
  logic               in_ready_o;
  logic [BF_DW-1:0]   in_data_i;
  logic               req_valid_i;
  logic               req_ready_o;
  logic [5:0]         req_width_i;
  logic               req_sext_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [BF_DW-1:0]   out_data_o;
  logic               flush_i;
  logic [BF_CNTW-1:0] level_o;

  modport slave (
    input  in_valid_i, in_data_i, req_valid_i, req_width_i, req_sext_i,
           out_ready_i, flush_i,
    output in_ready_o, req_ready_o, out_valid_o, out_data_o, level_o
  );

  modport master (
    output in_valid_i, in_data_i, req_valid_i, req_width_i, req_sext_i,
           out_ready_i, flush_i,
    input  in_ready_o, req_ready_o, out_valid_o, out_data_o, level_o
  );

endinterface

// File: rtl/raptor64_bf_extract.sv
// Combinational field extract: low width_i bits of bits_i, zero- or
// sign-extended to DW bits.
module raptor64_bf_extract
  import raptor64_bitfield_unpacker_pkg::*;
#(
  parameter int DW      = BF_DW,
  parameter bit SEXT_EN = 1'b1
) (
  input  logic [DW-1:0] bits_i,
  input  bf_width_t     width_i,
  input  logic          sext_i,
  output logic [DW-1:0] field_o
);

  logic [DW-1:0] mask;
  logic [DW-1:0] raw;
  logic [5:0]    top_idx;
  logic          sign;

  function automatic logic [DW-1:0] sext_fill(input logic [DW-1:0] f,
                                              input logic [DW-1:0] m,
                                              input logic          s);
    return s ? (f | ~m) : f;
  endfunction

  // A width of 64 shifts every one out, so the mask needs no special case.
  assign mask    = ~({DW{1'b1}} << width_i);
  assign raw     = bits_i & mask;
  assign top_idx = width_i[5:0] - 6'd1;
  assign sign    = bits_i[top_idx];

  generate
    if (SEXT_EN) begin : g_sext
      assign field_o = sext_fill(raw, mask, sign & sext_i);
    end else begin : g_zext
      logic unused_sext;
      assign unused_sext = sext_i ^ sign;
      assign field_o     = raw;
    end
  endgenerate

endmodule

// File: rtl/raptor64_bitfield_unpacker.sv
// Streaming LSB-first bitfield reader: 128-bit residual buffer, one field
// per cycle, registered result with valid/ready.
module raptor64_bitfield_unpacker
  import raptor64_bitfield_unpacker_pkg::*;
#(
  parameter int DW      = BF_DW,
  parameter bit SEXT_EN = 1'b1
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  raptor64_bitfield_unpacker_if.slave bus
);

  localparam int BW = 2 * DW;

  bf_cnt_t       cnt_q, cnt_d, cnt_c;
  logic [BW-1:0] bits_q, bits_d, bits_c;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [DW-1:0] field;

  bf_width_t     w;
  logic          slot_free;
  logic          in_ready;
  logic          req_ready;
  logic          in_fire;
  logic          req_fire;

  assign w         = bf_width_decode(bus.req_width_i);
  assign slot_free = ~out_valid_q | bus.out_ready_i;
  assign in_ready  = (cnt_q <= bf_cnt_t'(DW)) & ~bus.flush_i;
  assign req_ready = (cnt_q >= bf_cnt_t'(w)) & slot_free & ~bus.flush_i;
  assign in_fire   = bus.in_valid_i & in_ready;
  assign req_fire  = bus.req_valid_i & req_ready;

  raptor64_bf_extract #(
    .DW      (DW),
    .SEXT_EN (SEXT_EN)
  ) u_extract (
    .bits_i  (bits_q[DW-1:0]),
    .width_i (w),
    .sext_i  (bus.req_sext_i),
    .field_o (field)
  );

  // Consume first, then append: the new word lands just above whatever
  // survives the consume, which is always at or below bit DW.
  always_comb begin
    bits_c      = bits_q;
    cnt_c       = cnt_q;
    bits_d      = bits_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (req_fire) begin
      bits_c = bits_q >> w;
      cnt_c  = cnt_q - bf_cnt_t'(w);
    end

    bits_d = bits_c;
    cnt_d  = cnt_c;
    if (in_fire) begin
      bits_d = bits_c | ({{DW{1'b0}}, bus.in_data_i} << cnt_c);
      cnt_d  = cnt_c + bf_cnt_t'(DW);
    end

    if (bus.flush_i) begin
      bits_d = '0;
      cnt_d  = '0;
    end

    // A flush leaves the output register alone so a pending field still drains.
    if (req_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = field;
    end else if (bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      bits_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.req_ready_o = req_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.level_o     = cnt_q;

endmodule

// File: tb/tb_raptor64_bitfield_unpacker.sv
// Bench for the bitfield unpacker: directed plan plus randomized traffic
// checked against a bit-queue stream model.
module tb_raptor64_bitfield_unpacker;

  logic clk;
  logic rst_n;

  raptor64_bitfield_unpacker_if ifc ();

  raptor64_bitfield_unpacker dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: the buffered stream as a queue of bits, earliest bit at the front.
  bit          mq[$];
  bit          mvalid;
  logic [63:0] mdata;
  bit          in_fired;
  bit          req_fired;

  localparam logic [63:0] W1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] W2 = 64'hFEDCBA9876543210;
  localparam logic [63:0] WA = 64'hA5A5A5A5A5A5A5A5;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mvalid = 1'b0;
    mdata  = '0;
  endtask

  task automatic present(input logic iv, input logic [63:0] id, input logic rv,
                         input logic [5:0] rw, input logic rs, input logic ordy,
                         input logic fl);
    ifc.in_valid_i  = iv;
    ifc.in_data_i   = id;
    ifc.req_valid_i = rv;
    ifc.req_width_i = rw;
    ifc.req_sext_i  = rs;
    ifc.out_ready_i = ordy;
    ifc.flush_i     = fl;
    #1;
  endtask

  // Called just after a falling edge; checks readiness, advances the model
  // across one rising edge, then checks registered state.
  task automatic step(input logic iv, input logic [63:0] id, input logic rv,
                      input logic [5:0] rw, input logic rs, input logic ordy,
                      input logic fl);
    int          wm;
    bit          rin;
    bit          rreq;
    logic [63:0] field;
    present(iv, id, rv, rw, rs, ordy, fl);
    wm   = (rw == 6'd0) ? 64 : int'(rw);
    rin  = (mq.size() <= 64) && !fl;
    rreq = (mq.size() >= wm) && (!mvalid || ordy) && !fl;
    chk("in_ready", {63'd0, ifc.in_ready_o}, {63'd0, rin});
    chk("req_ready", {63'd0, ifc.req_ready_o}, {63'd0, rreq});
    in_fired  = iv && rin;
    req_fired = rv && rreq;
    if (fl) mq.delete();
    field = '0;
    if (req_fired) begin
      for (int i = 0; i < wm; i++) field[i] = mq.pop_front();
      if (rs && field[wm-1])
        for (int i = wm; i < 64; i++) field[i] = 1'b1;
    end
    if (in_fired)
      for (int i = 0; i < 64; i++) mq.push_back(id[i]);
    if (req_fired) begin
      mvalid = 1'b1;
      mdata  = field;
    end else if (ordy) begin
      mvalid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("level", {56'd0, ifc.level_o}, 64'(mq.size()));
    chk("out_valid", {63'd0, ifc.out_valid_o}, {63'd0, mvalid});
    if (mvalid) chk("out_data", ifc.out_data_o, mdata);
  endtask

  task automatic push(input logic [63:0] d);
    step(1'b1, d, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic req(input logic [5:0] rw, input logic rs, input logic ordy);
    step(1'b0, 64'd0, 1'b1, rw, rs, ordy, 1'b0);
  endtask

  task automatic flush();
    step(1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic async_reset_check();
    present(1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {63'd0, ifc.in_ready_o}, 64'd1);
    chk("arst_req_ready", {63'd0, ifc.req_ready_o}, 64'd0);
    chk("arst_level", {56'd0, ifc.level_o}, 64'd0);
    chk("arst_out_valid", {63'd0, ifc.out_valid_o}, 64'd0);
    chk("arst_out_data", ifc.out_data_o, 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_run(input int n);
    logic        hv_in, hv_req, hs;
    logic [63:0] hd;
    logic [5:0]  hw;
    logic        ordy, fl;
    hv_in = 1'b0; hv_req = 1'b0; hs = 1'b0; hd = '0; hw = '0;
    for (int c = 0; c < n; c++) begin
      if (!hv_in) begin
        hv_in = ($urandom_range(0, 2) != 0);
        hd    = {$urandom, $urandom};
      end
      if (!hv_req) begin
        hv_req = ($urandom_range(0, 3) != 0);
        hs     = $urandom_range(0, 1) == 1;
        case ($urandom_range(0, 3))
          0:       hw = 6'd0;
          1:       hw = 6'($urandom_range(1, 63));
          default: hw = 6'($urandom_range(1, 16));
        endcase
      end
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 79) == 0);
      step(hv_in, hd, hv_req, hw, hs, ordy, fl);
      if (in_fired)  hv_in  = 1'b0;
      if (req_fired) hv_req = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0;
    model_reset();
    present(1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, ifc.in_ready_o}, 64'd1);
    chk("rst_req_ready", {63'd0, ifc.req_ready_o}, 64'd0);
    chk("rst_level", {56'd0, ifc.level_o}, 64'd0);
    chk("rst_out_valid", {63'd0, ifc.out_valid_o}, 64'd0);
    chk("rst_out_data", ifc.out_data_o, 64'd0);
    rst_n = 1'b1;

    // Basic extraction
    push(W1);
    push(W2);
    chk("lit_level128", {56'd0, ifc.level_o}, 64'd128);
    req(6'd4, 1'b0, 1'b1);
    chk("lit_w4", ifc.out_data_o, 64'hF);
    chk("lit_level124", {56'd0, ifc.level_o}, 64'd124);
    req(6'd8, 1'b0, 1'b1);
    chk("lit_w8", ifc.out_data_o, 64'hDE);
    chk("lit_level116", {56'd0, ifc.level_o}, 64'd116);
    req(6'd52, 1'b0, 1'b1);
    chk("lit_w52", ifc.out_data_o, 64'h0123456789ABC);
    chk("lit_level64", {56'd0, ifc.level_o}, 64'd64);

    // Field straddling the word boundary
    flush();
    push(W1);
    push(W2);
    req(6'd60, 1'b0, 1'b1);
    chk("lit_w60", ifc.out_data_o, 64'h0123456789ABCDEF & 64'h0FFFFFFFFFFFFFFF);
    req(6'd8, 1'b0, 1'b1);
    chk("lit_straddle", ifc.out_data_o, 64'h00);
    chk("lit_straddle_lvl", {56'd0, ifc.level_o}, 64'd60);

    // Sign extension
    flush();
    push(64'h80);
    req(6'd8, 1'b1, 1'b1);
    chk("lit_sext1", ifc.out_data_o, 64'hFFFFFFFFFFFFFF80);
    flush();
    push(64'h80);
    req(6'd8, 1'b0, 1'b1);
    chk("lit_sext0", ifc.out_data_o, 64'h80);

    // Width code 0 means 64 bits
    flush();
    push(WA);
    req(6'd0, 1'b0, 1'b1);
    chk("lit_w64", ifc.out_data_o, WA);
    chk("lit_w64_lvl", {56'd0, ifc.level_o}, 64'd0);
    push(WA);
    req(6'd1, 1'b0, 1'b1);
    present(1'b0, 64'd0, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0);
    chk("lit_w64_stall", {63'd0, ifc.req_ready_o}, 64'd0);
    req(6'd0, 1'b0, 1'b1);
    chk("lit_lvl63", {56'd0, ifc.level_o}, 64'd63);

    // Backpressure, then simultaneous word + request at level 40
    flush();
    push(W2);
    req(6'd8, 1'b0, 1'b0);
    present(1'b1, W1, 1'b1, 6'd8, 1'b0, 1'b0, 1'b0);
    chk("lit_bp_req_stall", {63'd0, ifc.req_ready_o}, 64'd0);
    chk("lit_bp_in_ready", {63'd0, ifc.in_ready_o}, 64'd1);
    step(1'b1, W1, 1'b1, 6'd8, 1'b0, 1'b0, 1'b0);
    chk("lit_bp_hold", ifc.out_data_o, 64'h10);
    chk("lit_bp_lvl", {56'd0, ifc.level_o}, 64'd120);
    req(6'd0, 1'b0, 1'b1);
    req(6'd16, 1'b0, 1'b1);
    chk("lit_lvl40", {56'd0, ifc.level_o}, 64'd40);
    step(1'b1, WA, 1'b1, 6'd16, 1'b0, 1'b1, 1'b0);
    chk("lit_lvl88", {56'd0, ifc.level_o}, 64'd88);
    req(6'd0, 1'b0, 1'b1);
    req(6'd24, 1'b0, 1'b1);
    chk("lit_drain_lvl", {56'd0, ifc.level_o}, 64'd0);

    // Flush with a pending result
    push(W1);
    push(W2);
    req(6'd28, 1'b0, 1'b0);
    chk("lit_lvl100", {56'd0, ifc.level_o}, 64'd100);
    step(1'b1, W1, 1'b1, 6'd4, 1'b0, 1'b0, 1'b1);
    chk("lit_flush_lvl", {56'd0, ifc.level_o}, 64'd0);
    chk("lit_flush_keep_v", {63'd0, ifc.out_valid_o}, 64'd1);
    chk("lit_flush_keep_d", ifc.out_data_o, 64'h9ABCDEF);
    step(1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic, an asynchronous reset mid-stream, more traffic
    rand_run(2500);
    push({$urandom, $urandom});
    async_reset_check();
    rand_run(1500);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/raptor64_bitfield_unpacker.md
Name: raptor64_bitfield_unpacker

Overview:
- Streaming bitfield reader: accepts packed 64-bit words and returns variable-width fields (1..64 bits), LSB-first, zero- or sign-extended to 64 bits.
- Inverse of the bitfield insert/pack datapath: the packer writes fields into words, and this block reads them back out. Serves bit-stream decode (compressed code, packed tables) in front of the Raptor64 execute stage.
- Holds up to two words of residual bits, so fields may straddle word boundaries.

Parameters:
- DW, 64, data/field width in bits; only 64 is supported. DW sets the port widths. Buffer capacity is 2*DW.
- SEXT_EN, 1, when 0 the sign-extension logic is removed and req_sext_i is ignored.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  packed word available
- in_ready_o  out  1  block can accept a word this cycle
- in_data_i  in  64  packed word; bit 0 is the earliest bit in the stream
- req_valid_i  in  1  field request present
- req_ready_o  out  1  request accepted this cycle
- req_width_i  in  6  field width; 0 encodes 64, 1..63 literal
- req_sext_i  in  1  sign-extend the field from bit (width-1)
- out_valid_o  out  1  field result valid
- out_ready_i  in  1  consumer takes the result
- out_data_o  out  64  extracted field
- flush_i  in  1  discard all buffered bits (byte-realign/restart)
- level_o  out  8  buffered bit count, 0..128

Behaviour:
- Handshakes:
  - Transfer occurs on valid&ready at the rising edge.
  - valid must stay high and data stable until ready.
  - out_data_o holds while out_valid_o=1 and out_ready_i=0.
- State: 128-bit buffer buf, 8-bit count cnt, output register plus a valid flag.
  - Bit i of the stream lives at buf[i] while i < cnt.
  - Bits at index >= cnt are zero.
- in_ready_o = (cnt <= 64) & ~flush_i. This is combinational from registered state, with no dependence on in_valid_i.
- Let w = (req_width_i==0) ? 64 : req_width_i. Output slot is free when out_valid_o=0 or out_ready_i=1.
- req_ready_o = (cnt >= w) & slot free & ~flush_i.
- On request accept:
  - Field = buf[w-1:0], upper bits zeroed.
  - If req_sext_i & SEXT_EN, bits 63..w are copied from bit w-1.
  - The field is registered, so out_valid_o rises the next cycle (latency 1).
  - buf is shifted right by w and cnt -= w.
- On word accept: in_data_i is written at position cnt_after_consume. It is placed above the remaining bits, never overwriting them.
- Same-cycle word accept and request accept:
  - Consume happens first: cnt_next = cnt - w + 64.
  - New word placed at bit (cnt - w).
  - Guaranteed in range because cnt <= 64 at accept.
- Back-to-back: one field per cycle is sustained while the consumer asserts out_ready_i. Throughput is also limited by one input word per cycle.
- Empty: cnt < w stalls the request (req_ready_o=0) until enough words arrive. There is no partial-field output.
- Full: cnt > 64 deasserts in_ready_o. A word is never dropped.
- Flush:
  - Next edge: cnt=0, buf=0.
  - A pending output result is kept and still delivered.
  - Requests and words presented in the flush cycle are not accepted.
- Reset (async, rst_ni=0): cnt=0, buf=0, out_valid_o=0, out_data_o=0, in_ready_o=1, req_ready_o=0, level_o=0.
  - Reset mid-operation discards everything. There is no partial completion.
  - Deassertion is synchronised externally.
- level_o = cnt (registered).
- No FSM beyond the output-valid flag. cnt alone encodes EMPTY (0), PARTIAL, and FULL (>64).

Decomposition:
- Shared package (Raptor64 defines include):
  - BF_DW=64
  - BF_BUFW=128
  - BF_CNTW=8
  - width-decode macro for the 0=64 encoding
- Natural sub-module: raptor64_bf_extract, a combinational field extract plus sign-extend given buf, w and sext. It is reusable by the datapath BFEXT path.
- The top level holds buf, cnt, handshakes and the output register.

Test Plan:
- Reset, then words 0x0123456789ABCDEF, 0xFEDCBA9876543210, requests w=4,8,52 sext=0 -> results 0xF, 0xDE, 0x0123456789ABC. level_o goes 128, 124, 116, 64.
- Straddle: after consuming 60 bits of word 1, request w=8 -> low nibble from bits 60..63 of word 1, high nibble from bits 0..3 of word 2. For the words above the result is 0x00.
- Sign-extend: word 0x0000000000000080, request w=8 sext=1 -> 0xFFFFFFFFFFFFFF80. The same request with sext=0 -> 0x80.
- Width 0 encoding: request req_width_i=0 on a full word 0xA5A5A5A5A5A5A5A5 -> that value, cnt-=64. With cnt=63, req_ready_o stays 0.
- Backpressure plus simultaneity: hold out_ready_i=0 with a result pending. The next request must stall while in_ready_o is unaffected. Then drive a word accept and a w=16 request in the same cycle at cnt=40 -> cnt=88, no bit lost.
- Flush and reset: flush at cnt=100 with a pending result -> result delivered, level_o=0 next cycle. Assert rst_ni low mid-stream -> all outputs at reset values immediately (asynchronous).
